// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the memory bus arbiter: command types, FSM states, bus owner.
package mem_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      TYPE_IMEM_READ  = 2'd0,
      TYPE_DMEM_READ  = 2'd1,
      TYPE_DMEM_WRITE = 2'd2
   } mem_type_t;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_BUSY,
      WAIT_DONE,
      RESP
   } arb_state_t;

   typedef enum logic {
      OWNER_IMEM = 1'b0,
      OWNER_DMEM = 1'b1
   } owner_t;

   // Command type for a data-port access
   function automatic mem_type_t dm_cmd_type(input logic we);
      return we ? TYPE_DMEM_WRITE : TYPE_DMEM_READ;
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester and SPI-controller signals of the arbiter, grouped as one bus.
interface mem_bus_arbiter_if;
   import mem_bus_arbiter_pkg::*;

   // instruction-fetch port
   logic        if_req_in;
   logic [15:0] if_addr_in;
   logic        if_ack_out;
   logic [15:0] if_data_out;
   logic        if_err_out;
   // data port
   logic        dm_req_in;
   logic        dm_we_in;
   logic [15:0] dm_addr_in;
   logic [7:0]  dm_wdata_in;
   logic        dm_ack_out;
   logic [7:0]  dm_rdata_out;
   logic        dm_err_out;
   // SPI memory controller side
   logic [15:0] mem_addr_out;
   logic        mem_addr_valid_out;
   mem_type_t   mem_type_out;
   logic [7:0]  mem_wdata_out;
   logic [15:0] mem_flash_data_in;
   logic        mem_flash_valid_in;
   logic [7:0]  mem_psram_data_in;
   logic        mem_psram_valid_in;
   logic        mem_busy_in;

   // arbiter side
   modport slave (
      input  if_req_in, if_addr_in, dm_req_in, dm_we_in, dm_addr_in, dm_wdata_in,
             mem_flash_data_in, mem_flash_valid_in, mem_psram_data_in,
             mem_psram_valid_in, mem_busy_in,
      output if_ack_out, if_data_out, if_err_out, dm_ack_out, dm_rdata_out, dm_err_out,
             mem_addr_out, mem_addr_valid_out, mem_type_out, mem_wdata_out
   );

   // requesters plus controller side
   modport master (
      output if_req_in, if_addr_in, dm_req_in, dm_we_in, dm_addr_in, dm_wdata_in,
             mem_flash_data_in, mem_flash_valid_in, mem_psram_data_in,
             mem_psram_valid_in, mem_busy_in,
      input  if_ack_out, if_data_out, if_err_out, dm_ack_out, dm_rdata_out, dm_err_out,
             mem_addr_out, mem_addr_valid_out, mem_type_out, mem_wdata_out
   );

endinterface

// File: rtl/mem_bus_arbiter_watchdog.sv
// Transaction watchdog: counts enabled cycles, flags the WDT_CYCLES-th one.
module mem_arb_watchdog #(
   parameter int unsigned WDT_CYCLES = 4096
) (
   input  logic clk_in,
   input  logic reset_in,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int unsigned CW = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES + 1) : 1;

   logic [CW-1:0] count;

   // count cycles while enabled, restart whenever cleared
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable)
         count <= count + CW'(1);
   end

   // the current cycle is the WDT_CYCLES-th counted one
   assign expire = enable && !clear && (count == CW'(WDT_CYCLES - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Alternating-priority arbiter between instruction fetch and data ports
// in front of a single SPI memory controller, with a per-transaction watchdog.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned WDT_CYCLES = 4096,
   parameter bit          DMEM_FIRST = 1'b1
) (
   input  logic             clk_in,
   input  logic             reset_in,
   mem_bus_arbiter_if.slave bus
);

   arb_state_t  state;
   owner_t      owner;
   logic        prio_dm;
   logic [15:0] flash_res;
   logic [7:0]  psram_res;
   logic        wdt_en;
   logic        wdt_expire;
   logic        grant_dm;

   assign wdt_en   = (state == ISSUE) || (state == WAIT_BUSY) || (state == WAIT_DONE);
   assign grant_dm = bus.dm_req_in && (!bus.if_req_in || prio_dm);

   mem_arb_watchdog #(.WDT_CYCLES(WDT_CYCLES)) u_wdt (
      .clk_in   (clk_in),
      .reset_in (reset_in),
      .clear    (!wdt_en),
      .enable   (wdt_en),
      .expire   (wdt_expire)
   );

   // arbitration FSM with registered bus and completion outputs
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         state                  <= IDLE;
         owner                  <= OWNER_IMEM;
         prio_dm                <= DMEM_FIRST;
         flash_res              <= '0;
         psram_res              <= '0;
         bus.if_ack_out         <= 1'b0;
         bus.if_err_out         <= 1'b0;
         bus.if_data_out        <= '0;
         bus.dm_ack_out         <= 1'b0;
         bus.dm_err_out         <= 1'b0;
         bus.dm_rdata_out       <= '0;
         bus.mem_addr_out       <= '0;
         bus.mem_addr_valid_out <= 1'b0;
         bus.mem_type_out       <= TYPE_IMEM_READ;
         bus.mem_wdata_out      <= '0;
      end else begin
         bus.if_ack_out         <= 1'b0;
         bus.if_err_out         <= 1'b0;
         bus.dm_ack_out         <= 1'b0;
         bus.dm_err_out         <= 1'b0;
         bus.mem_addr_valid_out <= 1'b0;

         if (state != IDLE) begin
            if (bus.mem_flash_valid_in) flash_res <= bus.mem_flash_data_in;
            if (bus.mem_psram_valid_in) psram_res <= bus.mem_psram_data_in;
         end

         if (wdt_expire) begin
            state <= RESP;
            if (owner == OWNER_DMEM) begin
               bus.dm_ack_out <= 1'b1;
               bus.dm_err_out <= 1'b1;
            end else begin
               bus.if_ack_out <= 1'b1;
               bus.if_err_out <= 1'b1;
            end
         end else begin
            unique case (state)
               IDLE: begin
                  if (!bus.mem_busy_in && (bus.if_req_in || bus.dm_req_in)) begin
                     state                  <= ISSUE;
                     bus.mem_addr_valid_out <= 1'b1;
                     if (grant_dm) begin
                        owner             <= OWNER_DMEM;
                        prio_dm           <= 1'b0;
                        bus.mem_addr_out  <= bus.dm_addr_in;
                        bus.mem_type_out  <= dm_cmd_type(bus.dm_we_in);
                        bus.mem_wdata_out <= bus.dm_wdata_in;
                     end else begin
                        owner             <= OWNER_IMEM;
                        prio_dm           <= 1'b1;
                        bus.mem_addr_out  <= bus.if_addr_in;
                        bus.mem_type_out  <= TYPE_IMEM_READ;
                        bus.mem_wdata_out <= '0;
                     end
                  end
               end
               ISSUE:     state <= WAIT_BUSY;
               WAIT_BUSY: if (bus.mem_busy_in) state <= WAIT_DONE;
               WAIT_DONE: begin
                  if (!bus.mem_busy_in) begin
                     state <= RESP;
                     // data arriving with the falling busy bypasses the result register
                     if (owner == OWNER_IMEM) begin
                        bus.if_ack_out  <= 1'b1;
                        bus.if_data_out <= bus.mem_flash_valid_in ? bus.mem_flash_data_in : flash_res;
                     end else begin
                        bus.dm_ack_out <= 1'b1;
                        if (bus.mem_type_out == TYPE_DMEM_READ)
                           bus.dm_rdata_out <= bus.mem_psram_valid_in ? bus.mem_psram_data_in : psram_res;
                     end
                  end
               end
               RESP:      state <= IDLE;
               default:   state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter with a behavioural SPI controller model.
module tb_mem_bus_arbiter;
   import mem_bus_arbiter_pkg::*;

   localparam int WDT = 16;

   logic clk_in = 1'b0;
   logic reset_in;
   always #5 clk_in = ~clk_in;

   mem_bus_arbiter_if bus();

   mem_bus_arbiter #(.WDT_CYCLES(WDT), .DMEM_FIRST(1'b1)) dut (
      .clk_in   (clk_in),
      .reset_in (reset_in),
      .bus      (bus)
   );

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- memory models ----------------
   logic [7:0] psram_mem [logic [15:0]];
   logic [7:0] dm_shadow [logic [15:0]];

   function automatic logic [15:0] flash_rd(input logic [15:0] a);
      if (a == 16'h0004) return 16'hA5C3;
      return {~a[7:0], a[15:8]} ^ 16'h1234;
   endfunction

   function automatic logic [7:0] psram_default(input logic [15:0] a);
      return a[7:0] ^ 8'h3C;
   endfunction

   // ---------------- controller model ----------------
   logic      ctrl_busy    = 1'b0;
   logic      force_busy   = 1'b0;
   logic      ctrl_respond = 1'b1;
   int        busy_len     = 3;
   int        rem          = 0;
   mem_type_t cur_type;
   logic [15:0] cur_addr;

   assign bus.mem_busy_in = ctrl_busy | force_busy;

   always @(negedge clk_in) begin
      bus.mem_flash_valid_in = 1'b0;
      bus.mem_psram_valid_in = 1'b0;
      if (reset_in) begin
         ctrl_busy = 1'b0;
         rem       = 0;
      end else if (rem > 0) begin
         rem--;
         if (rem == 0) begin
            ctrl_busy = 1'b0;
            if (cur_type == TYPE_IMEM_READ) begin
               bus.mem_flash_valid_in = 1'b1;
               bus.mem_flash_data_in  = flash_rd(cur_addr);
            end else if (cur_type == TYPE_DMEM_READ) begin
               bus.mem_psram_valid_in = 1'b1;
               bus.mem_psram_data_in  = psram_mem.exists(cur_addr) ? psram_mem[cur_addr]
                                                                   : psram_default(cur_addr);
            end
         end
      end else if (bus.mem_addr_valid_out && ctrl_respond) begin
         ctrl_busy = 1'b1;
         rem       = busy_len;
         cur_type  = bus.mem_type_out;
         cur_addr  = bus.mem_addr_out;
         if (cur_type == TYPE_DMEM_WRITE) psram_mem[cur_addr] = bus.mem_wdata_out;
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      mem_type_t   t;
      logic [15:0] a;
      logic [7:0]  wd;
   } cmd_t;

   typedef struct {
      logic [15:0] d;
      logic        err;
      int          lat;
   } rsp_t;

   cmd_t cmd_q[$];
   rsp_t if_q[$];
   rsp_t dm_q[$];

   int   cyc = 0;
   int   issue_cyc = 0;
   int   n_issue = 0;
   int   n_if_ack = 0;
   int   n_dm_ack = 0;
   logic prev_valid = 1'b0, prev_ifack = 1'b0, prev_dmack = 1'b0;
   logic [7:0] dm_last = 8'h00;
   cmd_t mc;
   rsp_t mr;

   always @(posedge clk_in) cyc++;

   always @(negedge clk_in) begin
      if (reset_in) begin
         prev_valid = 1'b0;
         prev_ifack = 1'b0;
         prev_dmack = 1'b0;
      end else begin
         if (bus.mem_addr_valid_out) begin
            check("issue_one_cycle", 32'(prev_valid), 32'(0));
            n_issue++;
            issue_cyc = cyc;
            if (cmd_q.size() == 0) check("issue_unexpected", 32'(1), 32'(0));
            else begin
               mc = cmd_q.pop_front();
               check("cmd_type", 32'(bus.mem_type_out), 32'(mc.t));
               check("cmd_addr", 32'(bus.mem_addr_out), 32'(mc.a));
               if (mc.t == TYPE_DMEM_WRITE) check("cmd_wdata", 32'(bus.mem_wdata_out), 32'(mc.wd));
            end
         end
         if (bus.if_ack_out) begin
            n_if_ack++;
            check("if_ack_one_cycle", 32'(prev_ifack), 32'(0));
            if (if_q.size() == 0) check("if_ack_unexpected", 32'(1), 32'(0));
            else begin
               mr = if_q.pop_front();
               check("if_data", 32'(bus.if_data_out), 32'(mr.d));
               check("if_err", 32'(bus.if_err_out), 32'(mr.err));
               check("if_latency", 32'(cyc - issue_cyc), 32'(mr.lat));
            end
         end
         if (bus.dm_ack_out) begin
            n_dm_ack++;
            check("dm_ack_one_cycle", 32'(prev_dmack), 32'(0));
            if (dm_q.size() == 0) check("dm_ack_unexpected", 32'(1), 32'(0));
            else begin
               mr = dm_q.pop_front();
               check("dm_rdata", 32'(bus.dm_rdata_out), 32'(mr.d[7:0]));
               check("dm_err", 32'(bus.dm_err_out), 32'(mr.err));
               check("dm_latency", 32'(cyc - issue_cyc), 32'(mr.lat));
            end
         end
         prev_valid = bus.mem_addr_valid_out;
         prev_ifack = bus.if_ack_out;
         prev_dmack = bus.dm_ack_out;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push_cmd(input mem_type_t t, input logic [15:0] a, input logic [7:0] wd);
      cmd_t c;
      c.t = t; c.a = a; c.wd = wd;
      cmd_q.push_back(c);
   endtask

   task automatic if_txn(input logic [15:0] a);
      rsp_t r;
      bit   got = 1'b0;
      r.d = flash_rd(a); r.err = 1'b0; r.lat = busy_len + 1;
      if_q.push_back(r);
      bus.if_addr_in = a;
      bus.if_req_in  = 1'b1;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk_in);
         got = bus.if_ack_out;
      end
      check("if_ack_seen", 32'(got), 32'(1));
      bus.if_req_in = 1'b0;
   endtask

   task automatic dm_txn(input logic we, input logic [15:0] a, input logic [7:0] wd, input logic err);
      rsp_t r;
      bit   got = 1'b0;
      if (err) r.lat = WDT;
      else     r.lat = busy_len + 1;
      if (!err && we) dm_shadow[a] = wd;
      else if (!err)  dm_last = dm_shadow.exists(a) ? dm_shadow[a] : psram_default(a);
      r.d = {8'h00, dm_last}; r.err = err;
      dm_q.push_back(r);
      bus.dm_addr_in  = a;
      bus.dm_we_in    = we;
      bus.dm_wdata_in = wd;
      bus.dm_req_in   = 1'b1;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk_in);
         got = bus.dm_ack_out;
      end
      check("dm_ack_seen", 32'(got), 32'(1));
      bus.dm_req_in = 1'b0;
   endtask

   task automatic check_reset_outputs();
      check("rst_if_ack",   32'(bus.if_ack_out),         32'(0));
      check("rst_if_err",   32'(bus.if_err_out),         32'(0));
      check("rst_if_data",  32'(bus.if_data_out),        32'(0));
      check("rst_dm_ack",   32'(bus.dm_ack_out),         32'(0));
      check("rst_dm_err",   32'(bus.dm_err_out),         32'(0));
      check("rst_dm_rdata", 32'(bus.dm_rdata_out),       32'(0));
      check("rst_valid",    32'(bus.mem_addr_valid_out), 32'(0));
      check("rst_addr",     32'(bus.mem_addr_out),       32'(0));
      check("rst_wdata",    32'(bus.mem_wdata_out),      32'(0));
      check("rst_type",     32'(bus.mem_type_out),       32'(TYPE_IMEM_READ));
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int  n0;
      int  rel;
      int  acks_before;
      bit  seen;

      bus.if_req_in   = 1'b0;
      bus.if_addr_in  = '0;
      bus.dm_req_in   = 1'b0;
      bus.dm_we_in    = 1'b0;
      bus.dm_addr_in  = '0;
      bus.dm_wdata_in = '0;
      reset_in        = 1'b1;
      repeat (3) @(negedge clk_in);
      check_reset_outputs();
      reset_in = 1'b0;
      @(negedge clk_in);

      // contention right after reset: data holds priority first, then alternation
      push_cmd(TYPE_DMEM_READ, 16'h0030, 8'h00);
      push_cmd(TYPE_IMEM_READ, 16'h0100, 8'h00);
      push_cmd(TYPE_DMEM_READ, 16'h0031, 8'h00);
      push_cmd(TYPE_IMEM_READ, 16'h0104, 8'h00);
      fork
         begin dm_txn(1'b0, 16'h0030, 8'h00, 1'b0); dm_txn(1'b0, 16'h0031, 8'h00, 1'b0); end
         begin if_txn(16'h0100); if_txn(16'h0104); end
      join
      repeat (2) @(negedge clk_in);
      check("alt_if_acks", 32'(n_if_ack), 32'(2));
      check("alt_dm_acks", 32'(n_dm_ack), 32'(2));

      // instruction fetch from flash
      push_cmd(TYPE_IMEM_READ, 16'h0004, 8'h00);
      if_txn(16'h0004);

      // data write then read back
      push_cmd(TYPE_DMEM_WRITE, 16'h0010, 8'h55);
      dm_txn(1'b1, 16'h0010, 8'h55, 1'b0);
      push_cmd(TYPE_DMEM_READ, 16'h0010, 8'h00);
      dm_txn(1'b0, 16'h0010, 8'h00, 1'b0);
      check("if_data_hold", 32'(bus.if_data_out), 32'(16'hA5C3));

      // watchdog abort when busy never rises, then normal service
      ctrl_respond = 1'b0;
      push_cmd(TYPE_DMEM_WRITE, 16'h0040, 8'hAA);
      dm_txn(1'b1, 16'h0040, 8'hAA, 1'b1);
      ctrl_respond = 1'b1;
      push_cmd(TYPE_DMEM_READ, 16'h0010, 8'h00);
      dm_txn(1'b0, 16'h0010, 8'h00, 1'b0);

      // busy held in IDLE blocks the grant
      force_busy = 1'b1;
      push_cmd(TYPE_IMEM_READ, 16'h0200, 8'h00);
      n0 = n_issue;
      fork
         if_txn(16'h0200);
         begin
            repeat (6) @(negedge clk_in);
            check("busy_blocks_issue", 32'(n_issue), 32'(n0));
            force_busy = 1'b0;
            rel  = cyc;
            seen = 1'b0;
            for (int i = 0; i < 10 && !seen; i++) begin
               @(negedge clk_in);
               seen = (n_issue != n0);
            end
            check("issue_after_busy", 32'(seen && (issue_cyc - rel) <= 2), 32'(1));
         end
      join

      // reset during WAIT_DONE aborts without an ack
      busy_len = 10;
      push_cmd(TYPE_DMEM_READ, 16'h0020, 8'h00);
      acks_before   = n_dm_ack;
      bus.dm_addr_in = 16'h0020;
      bus.dm_we_in   = 1'b0;
      bus.dm_req_in  = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk_in);
         seen = bus.mem_busy_in;
      end
      check("busy_seen", 32'(seen), 32'(1));
      repeat (3) @(negedge clk_in);
      check("in_wait_done", 32'(dut.state), 32'(WAIT_DONE));
      reset_in      = 1'b1;
      bus.dm_req_in = 1'b0;
      #1;
      check("rst_state_idle", 32'(dut.state), 32'(IDLE));
      check_reset_outputs();
      repeat (2) @(negedge clk_in);
      reset_in = 1'b0;
      dm_last  = 8'h00;
      busy_len = 3;
      repeat (30) @(negedge clk_in);
      check("no_ack_after_abort", 32'(n_dm_ack), 32'(acks_before));

      // normal operation after reset
      push_cmd(TYPE_IMEM_READ, 16'h0004, 8'h00);
      if_txn(16'h0004);
      repeat (3) @(negedge clk_in);
      check("cmd_queue_drained", 32'(cmd_q.size()), 32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      check("global_timeout", 32'(1), 32'(0));
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "simulation time limit reached");
   end

endmodule
